// File: rtl/playlist_ctrl.sv
// Playback sequencer for the music player: turns debounced button edges and
// song-done reports into play / reset_play / new_song controls and a track index.
module playlist_ctrl #(
    parameter int NUM_SONGS   = 4,
    parameter int IDX_W       = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play_pause,
    input  logic             next,
    input  logic             prev,
    input  logic             song_done,
    input  logic [1:0]       mode,
    output logic             play,
    output logic             reset_play,
    output logic             new_song,
    output logic [IDX_W-1:0] song_idx
);

    localparam int                 CNT_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {S_RESET, S_PAUSE, S_PLAY, S_LOAD} state_t;

    state_t           state_q, state_d, target_q, target_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc, idx_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       btn, btn_q, evt;
    logic             play_q, play_d, reset_play_q, reset_play_d, new_song_q, new_song_d;

    logic             go_load;
    logic [IDX_W-1:0] go_idx;
    state_t           go_tgt;

    // Bit 0 = play_pause, bit 1 = next, bit 2 = prev; evt is the rising edge.
    assign btn = {prev, next, play_pause};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            assign evt[gi] = btn[gi] & ~btn_q[gi];
        end
    endgenerate

    assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    assign idx_dec = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        go_load  = 1'b0;
        go_idx   = idx_q;
        go_tgt   = S_PLAY;

        case (state_q)
            S_RESET: state_d = S_PAUSE;
            S_PAUSE: begin
                if (evt[0])      state_d = S_PLAY;
                else if (evt[1]) begin go_load = 1'b1; go_idx = idx_inc; end
                else if (evt[2]) begin go_load = 1'b1; go_idx = idx_dec; end
            end
            S_PLAY: begin
                if (evt[0])      state_d = S_PAUSE;
                else if (evt[1]) begin go_load = 1'b1; go_idx = idx_inc; end
                else if (evt[2]) begin go_load = 1'b1; go_idx = idx_dec; end
                else if (song_done) begin
                    go_load = 1'b1;
                    case (mode)
                        2'd0: go_idx = idx_inc;
                        2'd1: go_idx = idx_q;
                        2'd2: begin
                            if (idx_q == LAST_IDX) begin
                                go_idx = '0;
                                go_tgt = S_PAUSE;
                            end else begin
                                go_idx = idx_inc;
                            end
                        end
                        default: go_tgt = S_PAUSE;
                    endcase
                end
            end
            S_LOAD: begin
                // Everything arriving while loading is discarded.
                if (cnt_q == LAST_CNT) begin
                    state_d = target_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_RESET;
        endcase

        if (go_load) begin
            state_d  = S_LOAD;
            idx_d    = go_idx;
            target_d = go_tgt;
            cnt_d    = '0;
        end

        play_d       = (state_d == S_PLAY);
        reset_play_d = (state_d == S_RESET) || (state_d == S_LOAD);
        new_song_d   = go_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            target_q     <= S_PLAY;
            idx_q        <= '0;
            cnt_q        <= '0;
            btn_q        <= 3'b111;
            play_q       <= 1'b0;
            reset_play_q <= 1'b1;
            new_song_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            btn_q        <= btn;
            play_q       <= play_d;
            reset_play_q <= reset_play_d;
            new_song_q   <= new_song_d;
        end
    end

    assign play       = play_q;
    assign reset_play = reset_play_q;
    assign new_song   = new_song_q;
    assign song_idx   = idx_q;

endmodule

// File: tb/tb_playlist_ctrl.sv
// Bench for playlist_ctrl: hand-derived vector table for the directed corner
// cases, then random button/song_done traffic checked against a track-level model.
module tb_playlist_ctrl;

    localparam int N  = 4;
    localparam int LC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pp = 1'b0, nx = 1'b0, pv = 1'b0, sd = 1'b0;
    logic [1:0] md = 2'd0;
    logic       play, reset_play, new_song;
    logic [1:0] song_idx;

    int n_checks = 0;
    int n_fails  = 0;

    playlist_ctrl #(.NUM_SONGS(N), .IDX_W(2), .LOAD_CYCLES(LC)) dut (
        .clk        (clk),
        .reset      (reset),
        .play_pause (pp),
        .next       (nx),
        .prev       (pv),
        .song_done  (sd),
        .mode       (md),
        .play       (play),
        .reset_play (reset_play),
        .new_song   (new_song),
        .song_idx   (song_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, pp, nx, pv, sd;
        logic [1:0] md;
        logic       e_play, e_rp, e_ns;
        logic [1:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, p, n, v, s, input logic [1:0] m,
                                input logic ep, er, en, input logic [1:0] ei);
        vec_t t;
        t.rst = r; t.pp = p; t.nx = n; t.pv = v; t.sd = s; t.md = m;
        t.e_play = ep; t.e_rp = er; t.e_ns = en; t.e_idx = ei;
        vecs.push_back(t);
    endfunction

    // Track-level model: phase 0 reset, 1 paused, 2 playing, 3 loading.
    int     m_ph = 0, m_idx = 0, m_left = 0, m_tgt = 2;
    bit     m_first = 1'b0;
    bit [2:0] m_hist = 3'b111;

    function automatic void model_step(input bit r, p, n, v, s, input int mdv);
        bit e_p, e_n, e_v, go;
        int new_idx, new_tgt;
        m_first = 1'b0;
        if (r) begin
            m_ph = 0; m_idx = 0; m_left = 0; m_hist = 3'b111;
            return;
        end
        e_p = p && !m_hist[0];
        e_n = n && !m_hist[1];
        e_v = v && !m_hist[2];
        m_hist = {v, n, p};
        go = 1'b0; new_idx = m_idx; new_tgt = 2;
        case (m_ph)
            0: m_ph = 1;
            1, 2: begin
                if (e_p) m_ph = (m_ph == 1) ? 2 : 1;
                else if (e_n) begin go = 1'b1; new_idx = (m_idx + 1) % N; end
                else if (e_v) begin go = 1'b1; new_idx = (m_idx + N - 1) % N; end
                else if (s && m_ph == 2) begin
                    go = 1'b1;
                    case (mdv)
                        0: new_idx = (m_idx + 1) % N;
                        1: new_idx = m_idx;
                        2: if (m_idx == N - 1) begin new_idx = 0; new_tgt = 1; end
                           else new_idx = m_idx + 1;
                        default: new_tgt = 1;
                    endcase
                end
            end
            default: begin
                if (m_left == 0) m_ph = m_tgt;
                else m_left--;
            end
        endcase
        if (go) begin
            m_ph = 3; m_idx = new_idx; m_tgt = new_tgt; m_left = LC - 1; m_first = 1'b1;
        end
    endfunction

    task automatic apply(input logic r, p, n, v, s, input logic [1:0] m);
        @(negedge clk);
        reset = r; pp = p; nx = n; pv = v; sd = s; md = m;
        @(posedge clk);
        model_step(r, p, n, v, s, int'(m));
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got play/rp/ns/idx=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                     nm, act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    initial begin
        // reset 3 cycles, release, play/pause toggling
        add(1,0,0,0,0,0, 0,1,0,0); add(1,0,0,0,0,0, 0,1,0,0); add(1,0,0,0,0,0, 0,1,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 1,0,0,0); add(0,0,0,0,0,0, 1,0,0,0);
        add(0,1,0,0,0,0, 0,0,0,0); add(0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 1,0,0,0); add(0,0,0,0,0,0, 1,0,0,0);
        // prev wrap 0->3, next wrap 3->0, prev again
        add(0,0,0,1,0,0, 0,1,1,3); add(0,0,0,0,0,0, 0,1,0,3); add(0,0,0,0,0,0, 1,0,0,3);
        add(0,0,1,0,0,0, 0,1,1,0); add(0,0,0,0,0,0, 0,1,0,0); add(0,0,0,0,0,0, 1,0,0,0);
        add(0,0,0,1,0,0, 0,1,1,3); add(0,0,0,0,0,0, 0,1,0,3); add(0,0,0,0,0,0, 1,0,0,3);
        // STOP_AT_END at last track -> 0 and pause; song_done ignored when paused
        add(0,0,0,0,1,2, 0,1,1,0); add(0,0,0,0,1,2, 0,1,0,0);
        add(0,0,0,0,1,2, 0,0,0,0); add(0,0,0,0,1,2, 0,0,0,0);
        add(0,0,1,0,0,2, 0,1,1,1); add(0,0,0,0,0,2, 0,1,0,1); add(0,0,0,0,0,2, 1,0,0,1);
        add(0,0,0,0,1,2, 0,1,1,2); add(0,0,0,0,0,2, 0,1,0,2); add(0,0,0,0,0,2, 1,0,0,2);
        // play_pause beats next; a prev press inside LOAD is lost
        add(0,1,1,0,0,0, 0,0,0,2); add(0,0,0,0,0,0, 0,0,0,2);
        add(0,1,0,0,0,0, 1,0,0,2);
        add(0,0,1,0,0,0, 0,1,1,3); add(0,0,0,1,0,0, 0,1,0,3);
        add(0,0,0,0,0,0, 1,0,0,3); add(0,0,0,0,0,0, 1,0,0,3);
        // next held across reset release needs release then new press
        add(1,0,1,0,0,0, 0,1,0,0); add(0,0,1,0,0,0, 0,0,0,0); add(0,0,1,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(0,0,1,0,0,0, 0,1,1,1); add(0,0,0,0,0,0, 0,1,0,1); add(0,0,0,0,0,0, 1,0,0,1);
        // reset in the 2nd LOAD cycle
        add(0,0,1,0,0,0, 0,1,1,2); add(0,0,0,0,0,0, 0,1,0,2);
        add(1,0,0,0,0,0, 0,1,0,0); add(0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0, 1,0,0,0);
        add(0,0,1,0,0,0, 0,1,1,1); add(0,0,0,0,0,0, 0,1,0,1); add(0,0,0,0,0,0, 1,0,0,1);
        // REPEAT_ONE, SINGLE
        add(0,0,0,0,1,1, 0,1,1,1); add(0,0,0,0,0,1, 0,1,0,1); add(0,0,0,0,0,1, 1,0,0,1);
        add(0,0,0,0,1,3, 0,1,1,1); add(0,0,0,0,0,3, 0,1,0,1); add(0,0,0,0,0,3, 0,0,0,1);
        add(0,1,0,0,0,0, 1,0,0,1);
        // REPEAT_ALL, prev beats song_done, REPEAT_ALL wrap
        add(0,0,0,0,1,0, 0,1,1,2); add(0,0,0,0,0,0, 0,1,0,2); add(0,0,0,0,0,0, 1,0,0,2);
        add(0,0,0,1,1,0, 0,1,1,1); add(0,0,0,0,0,0, 0,1,0,1); add(0,0,0,0,0,0, 1,0,0,1);
        add(0,0,0,0,1,0, 0,1,1,2); add(0,0,0,0,0,0, 0,1,0,2); add(0,0,0,0,0,0, 1,0,0,2);
        add(0,0,0,0,1,0, 0,1,1,3); add(0,0,0,0,0,0, 0,1,0,3); add(0,0,0,0,0,0, 1,0,0,3);
        add(0,0,0,0,1,0, 0,1,1,0); add(0,0,0,0,0,0, 0,1,0,0); add(0,0,0,0,0,0, 1,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].pp, vecs[i].nx, vecs[i].pv, vecs[i].sd, vecs[i].md);
            $display("vec %0d: rst=%b pp=%b nx=%b pv=%b sd=%b mode=%0d -> play=%b rp=%b ns=%b idx=%0d",
                     i, vecs[i].rst, vecs[i].pp, vecs[i].nx, vecs[i].pv, vecs[i].sd, vecs[i].md,
                     play, reset_play, new_song, song_idx);
            check($sformatf("vec%0d", i), {play, reset_play, new_song, song_idx},
                  {vecs[i].e_play, vecs[i].e_rp, vecs[i].e_ns, vecs[i].e_idx});
        end

        for (int i = 0; i < 1500; i++) begin
            logic       r, p, n, v, s;
            logic [1:0] m;
            logic [4:0] exp_v;
            r = ($urandom_range(0, 149) == 0);
            p = ($urandom_range(0, 5) == 0);
            n = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 4) == 0);
            s = ($urandom_range(0, 3) == 0);
            m = 2'($urandom_range(0, 3));
            apply(r, p, n, v, s, m);
            exp_v = {m_ph == 2, (m_ph == 0) || (m_ph == 3), m_first, 2'(m_idx)};
            $display("rnd %0d: rst=%b pp=%b nx=%b pv=%b sd=%b mode=%0d -> play=%b rp=%b ns=%b idx=%0d",
                     i, r, p, n, v, s, m, play, reset_play, new_song, song_idx);
            check($sformatf("rnd%0d", i), {play, reset_play, new_song, song_idx}, exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
